// File: rtl/crc_serial_gen.sv
// Serial CRC generator/checker. Payload bits arrive LSB first while active=1.
// In generate mode the CRC is shifted out LSB first; in check mode a verdict is pulsed.
module crc_serial_gen #(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] TAPS      = 8'h44,
  parameter logic [CRC_WIDTH-1:0] SEED      = 8'hD8
) (
  input  logic clk,
  input  logic rst,
  input  logic data,
  input  logic active,
  input  logic mode,
  output logic crc,
  output logic valid,
  output logic busy,
  output logic chk_done,
  output logic chk_ok
);

  localparam int CNT_W = $clog2(CRC_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, SHIFT} state_t;

  state_t               state;
  logic [CRC_WIDTH-1:0] lfsr;
  logic [CNT_W-1:0]     cnt;
  logic                 mode_q;

  // Right-shifting LFSR; TAPS[CRC_WIDTH-1] is never consulted, the top stage always takes fb.
  function automatic logic [CRC_WIDTH-1:0] lfsr_step(input logic [CRC_WIDTH-1:0] s,
                                                     input logic                 d);
    logic                 fb;
    logic [CRC_WIDTH-1:0] n;
    fb = d ^ s[0];
    n  = '0;
    n[CRC_WIDTH-1] = fb;
    for (int i = 0; i < CRC_WIDTH - 1; i++)
      n[i] = s[i+1] ^ (TAPS[i] & fb);
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lfsr     <= SEED;
      cnt      <= '0;
      mode_q   <= 1'b0;
      crc      <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      chk_done <= 1'b0;
      chk_ok   <= 1'b0;
    end else begin
      chk_done <= 1'b0;
      chk_ok   <= 1'b0;
      case (state)
        IDLE: begin
          if (active) begin
            lfsr   <= lfsr_step(SEED, data);
            mode_q <= mode;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            lfsr <= SEED;
          end
        end
        CALC: begin
          if (active) begin
            lfsr <= lfsr_step(lfsr, data);
          end else if (mode_q) begin
            // Payload plus appended CRC leaves the register at zero when intact.
            chk_done <= 1'b1;
            chk_ok   <= (lfsr == '0);
            lfsr     <= SEED;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            crc   <= lfsr[0];
            valid <= 1'b1;
            lfsr  <= lfsr >> 1;
            cnt   <= CNT_W'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // active is ignored here; the frame's CRC always completes untouched.
          if (cnt == CNT_W'(CRC_WIDTH)) begin
            crc   <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            lfsr  <= SEED;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            crc  <= lfsr[0];
            lfsr <= lfsr >> 1;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          lfsr  <= SEED;
          cnt   <= '0;
          crc   <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_serial_gen.sv
// Bench for crc_serial_gen: three instances (8-bit seed 0, 8-bit defaults, 16-bit)
// checked against a bitwise software CRC reference.
module tb_crc_serial_gen;

  logic clk;
  logic rst;
  logic act [3];
  logic dat [3];
  logic md  [3];
  logic crc_o [3];
  logic vld   [3];
  logic bsy   [3];
  logic cdone [3];
  logic cok   [3];

  int n_chk;
  int n_err;

  crc_serial_gen #(.CRC_WIDTH(8), .TAPS(8'h44), .SEED(8'h00)) u0 (
    .clk(clk), .rst(rst), .data(dat[0]), .active(act[0]), .mode(md[0]),
    .crc(crc_o[0]), .valid(vld[0]), .busy(bsy[0]), .chk_done(cdone[0]), .chk_ok(cok[0]));

  crc_serial_gen u1 (
    .clk(clk), .rst(rst), .data(dat[1]), .active(act[1]), .mode(md[1]),
    .crc(crc_o[1]), .valid(vld[1]), .busy(bsy[1]), .chk_done(cdone[1]), .chk_ok(cok[1]));

  crc_serial_gen #(.CRC_WIDTH(16), .TAPS(16'h8408), .SEED(16'hFFFF)) u2 (
    .clk(clk), .rst(rst), .data(dat[2]), .active(act[2]), .mode(md[2]),
    .crc(crc_o[2]), .valid(vld[2]), .busy(bsy[2]), .chk_done(cdone[2]), .chk_ok(cok[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int u);
    return (u == 2) ? 16 : 8;
  endfunction

  // Textbook reflected bitwise CRC; the polynomial's top bit is implied.
  function automatic logic [31:0] ref_crc(input int u, input logic [63:0] bits, input int n);
    logic [31:0] poly, s, mask;
    int w;
    w    = wid(u);
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
    case (u)
      0:       begin poly = 32'h44;   s = 32'h0;    end
      1:       begin poly = 32'h44;   s = 32'hD8;   end
      default: begin poly = 32'h8408; s = 32'hFFFF; end
    endcase
    poly = (poly | (32'h1 << (w - 1))) & mask;
    for (int i = 0; i < n; i++) begin
      if ((s[0] ^ bits[i]) == 1'b1) s = (s >> 1) ^ poly;
      else                          s = s >> 1;
    end
    return s & mask;
  endfunction

  // Mode toggles after the first bit to show it is latched only at frame start.
  task automatic send(input int u, input logic m, input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      act[u] = 1'b1;
      dat[u] = bits[i];
      md[u]  = (i == 0) ? m : ~m;
      @(negedge clk);
    end
    act[u] = 1'b0;
    dat[u] = 1'b0;
  endtask

  task automatic collect(input int u, input bit inj, output logic [31:0] got, output int cyc);
    int  t;
    bit  bad_busy;
    got = '0; cyc = 0; t = 0; bad_busy = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!vld[u] && t < 10);
    chk("valid_rise", {31'b0, vld[u]}, 32'd1);
    while (vld[u] && cyc < 40) begin
      if (cyc < 32) got[cyc] = crc_o[u];
      if (!bsy[u]) bad_busy = 1;
      if (inj && (cyc == 2 || cyc == 3)) begin
        act[u] = 1'b1;
        dat[u] = 1'b1;
      end else begin
        act[u] = 1'b0;
        dat[u] = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    chk("busy_in_shift", {31'b0, bad_busy}, 32'd0);
    chk("busy_after", {31'b0, bsy[u]}, 32'd0);
    chk("crc_idle", {31'b0, crc_o[u]}, 32'd0);
  endtask

  task automatic gen_frame(input int u, input logic [63:0] bits, input int n, input bit inj,
                           input string tag);
    logic [31:0] got;
    int cyc;
    send(u, 1'b0, bits, n);
    collect(u, inj, got, cyc);
    chk({tag, "_crc"}, got, ref_crc(u, bits, n));
    chk({tag, "_len"}, cyc, wid(u));
  endtask

  task automatic chk_frame(input int u, input logic [63:0] bits, input int n, input string tag);
    int t;
    send(u, 1'b1, bits, n);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cdone[u] && t < 6);
    chk({tag, "_done"}, {31'b0, cdone[u]}, 32'd1);
    chk({tag, "_ok"}, {31'b0, cok[u]}, {31'b0, ref_crc(u, bits, n) == 32'd0});
    chk({tag, "_valid"}, {31'b0, vld[u]}, 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, cdone[u]}, 32'd0);
    chk({tag, "_busy"}, {31'b0, bsy[u]}, 32'd0);
  endtask

  initial begin
    logic [31:0] got, c;
    logic [63:0] bits;
    int cyc, n;

    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      act[u] = 1'b0; dat[u] = 1'b0; md[u] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", {27'b0, crc_o[0], vld[0], bsy[0], cdone[0], cok[0]}, 32'd0);
    chk("rst_outs16", {27'b0, crc_o[2], vld[2], bsy[2], cdone[2], cok[2]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Golden vector, compared to the literal expected CRC.
    send(0, 1'b0, 64'h01, 8);
    collect(0, 1'b0, got, cyc);
    chk("golden_crc", got, 32'hAB);
    chk("golden_len", cyc, 8);

    gen_frame(0, 64'h00, 8, 1'b0, "zero");

    // Zero-length frame: idle cycles produce nothing.
    repeat (4) @(negedge clk);
    chk("zero_len", {30'b0, vld[0], bsy[0]}, 32'd0);

    chk_frame(0, 64'hAB01, 16, "chk_good");
    chk_frame(0, 64'hAB01 ^ 64'h0800, 16, "chk_flip");
    chk("chk_flip_lit", {31'b0, cok[0]}, 32'd0);

    // Reset lands on the 4th payload bit; the next full frame must be clean.
    for (int i = 0; i < 3; i++) begin
      act[0] = 1'b1; dat[0] = (i == 0); md[0] = 1'b0;
      @(negedge clk);
    end
    act[0] = 1'b1; dat[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, bsy[0]}, 32'd0);
    chk("rst_mid_valid", {31'b0, vld[0]}, 32'd0);
    @(negedge clk);
    act[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    send(0, 1'b0, 64'h01, 8);
    collect(0, 1'b0, got, cyc);
    chk("post_rst_crc", got, 32'hAB);

    // active pulsed mid-shift must not disturb the CRC.
    gen_frame(0, 64'h01, 8, 1'b1, "inject");

    // Default parameters, back-to-back random frames with no reset.
    for (int k = 0; k < 10; k++) begin
      n    = $urandom_range(1, 32);
      bits = {$urandom, $urandom};
      gen_frame(1, bits, n, 1'b0, $sformatf("dflt%0d", k));
    end

    // Random check frames: payload with its CRC appended, sometimes one bit flipped.
    for (int k = 0; k < 6; k++) begin
      n    = $urandom_range(1, 24);
      bits = {32'b0, $urandom} & ((64'h1 << n) - 1);
      c    = ref_crc(1, bits, n);
      bits = bits | ({56'b0, c[7:0]} << n);
      if (k[0]) bits[$urandom_range(0, n + 7)] ^= 1'b1;
      chk_frame(1, bits, n + 8, $sformatf("rchk%0d", k));
    end

    // 16-bit instance with ASCII "11" payload, then random frames.
    gen_frame(2, 64'h3131, 16, 1'b0, "w16_ascii");
    for (int k = 0; k < 4; k++) begin
      n    = $urandom_range(1, 40);
      bits = {$urandom, $urandom};
      gen_frame(2, bits, n, 1'b0, $sformatf("w16_%0d", k));
    end
    bits = 64'h3131;
    c    = ref_crc(2, bits, 16);
    bits = bits | ({48'b0, c[15:0]} << 16);
    chk_frame(2, bits, 32, "w16_chk");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
